// File: rtl/servant_loader_pkg.sv
// Shared encodings for the servant RAM loader and its serial receiver.
package servant_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/servant_uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte valid
// and framing-error pulses.
module servant_uart_rx
    import servant_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       ferr_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q;
    logic        prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        rx_s;

    assign rx_s   = sync_q[1];
    assign data_o = sh_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_o = 1'b0;
        ferr_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == CW'(CLKS_PER_BIT/2 - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_o = rx_s;
                    ferr_o  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/servant_ram_loader.sv
// Boot loader: serial image -> Wishbone word writes, CPU held in reset until done.
// Define SERVANT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module servant_ram_loader
    import servant_loader_pkg::*;
#(
    parameter int depth        = 256,
    parameter int aw           = $clog2(depth),
    parameter int clks_per_bit = 16
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic          i_rx,
    output logic [aw-1:2] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_cpu_rst,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [31:0] MAX_WORDS = 32'(depth / 4);
`ifdef SERVANT_LOADER_CHECKSUM_EN
    localparam ldr_state_e POST_ST = ST_CHECK;
`else
    localparam ldr_state_e POST_ST = ST_DONE;
`endif

    ldr_state_e    state_q, state_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   len_q, len_d, len_nxt;
    logic [31:0]   word_q, word_d, word_nxt;
    logic [31:0]   dat_q, dat_d;
    logic [aw-3:0] wadr_q, wadr_d;
    logic          cyc_q, cyc_d;
    logic          last_word;
`ifdef SERVANT_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic [7:0] rx_byte;
    logic       rx_vld, rx_ferr;

    servant_uart_rx #(.CLKS_PER_BIT(clks_per_bit)) u_rx (
        .clk_i   (i_wb_clk),
        .rst_i   (i_wb_rst),
        .rx_i    (i_rx),
        .data_o  (rx_byte),
        .valid_o (rx_vld),
        .ferr_o  (rx_ferr)
    );

    assign len_nxt   = {rx_byte, len_q[31:8]};
    assign word_nxt  = {rx_byte, word_q[31:8]};
    assign last_word = (32'(wadr_q) + 32'd1) == len_q;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= ST_LEN;
            bcnt_q  <= '0;
            len_q   <= '0;
            word_q  <= '0;
            dat_q   <= '0;
            wadr_q  <= '0;
            cyc_q   <= 1'b0;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            dat_q   <= dat_d;
            wadr_q  <= wadr_d;
            cyc_q   <= cyc_d;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        len_d   = len_q;
        word_d  = word_q;
        dat_d   = dat_q;
        wadr_d  = wadr_q;
        cyc_d   = cyc_q;
`ifdef SERVANT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            ST_LEN: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_vld) begin
                    len_d  = len_nxt;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'(LEN_BYTES - 1)) begin
                        if (len_nxt > MAX_WORDS)  state_d = ST_ERR;
                        else if (len_nxt == '0)   state_d = POST_ST;
                        else                      state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // A byte takes far longer than a write, so no byte arrives while cyc is up.
                if (cyc_q) begin
                    if (i_wb_ack) begin
                        cyc_d  = 1'b0;
                        wadr_d = wadr_q + (aw-2)'(1);
                        if (last_word) state_d = POST_ST;
                    end
                end else if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_vld) begin
                    word_d = word_nxt;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef SERVANT_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_byte;
`endif
                    if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        cyc_d = 1'b1;
                        dat_d = word_nxt;
                    end
                end
            end
`ifdef SERVANT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_ferr)     state_d = ST_ERR;
                else if (rx_vld) state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: ;
        endcase
    end

    assign o_wb_adr  = wadr_q;
    assign o_wb_dat  = dat_q;
    assign o_wb_sel  = cyc_q ? 4'hF : 4'h0;
    assign o_wb_we   = cyc_q;
    assign o_wb_cyc  = cyc_q;
    assign o_cpu_rst = (state_q != ST_DONE);
    assign o_done    = (state_q == ST_DONE);
    assign o_err     = (state_q == ST_ERR);

endmodule

// File: tb/tb_servant_ram_loader.sv
// Randomised image loads into a RAM model; a negedge monitor scores each write.
module tb_servant_ram_loader;

    localparam int CPB = 16;
    localparam int MAXW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        ack = 1'b0;
    logic [7:2]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, cpu_rst, done, err;

    servant_ram_loader #(.depth(256), .clks_per_bit(CPB)) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_rx     (rx),
        .o_wb_adr (adr),
        .o_wb_dat (dat),
        .o_wb_sel (sel),
        .o_wb_we  (we),
        .o_wb_cyc (cyc),
        .i_wb_ack (ack),
        .o_cpu_rst(cpu_rst),
        .o_done   (done),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] adr; logic [31:0] dat; } wr_t;
    wr_t         exp_q[$];
    logic [31:0] mem [MAXW];
    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    bit          ack_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM slave: acks one cycle after seeing cyc.
    always @(posedge clk) begin
        if (rst) ack <= 1'b0;
        else if (cyc && we && !ack) begin
            ack <= 1'b1;
            mem[adr] <= dat;
        end else ack <= 1'b0;
    end

    always @(negedge clk) begin
        if (ack_prev) chk("cyc_drop", {63'd0, cyc}, 64'd0);
        ack_prev = cyc && ack && !rst;
        if (cyc && ack && !rst) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {58'd0, adr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_adr", {58'd0, adr}, {58'd0, e.adr});
                chk("wr_dat", {32'd0, dat}, {32'd0, e.dat});
                chk("wr_sel", {60'd0, sel}, 64'hF);
            end
        end
    end

    task automatic bits(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0; bits(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; bits(CPB); end
        rx = good_stop; bits(CPB);
        rx = 1'b1; bits(CPB);
    endtask

    task automatic do_reset();
        rst = 1'b1; rx = 1'b1;
        bits(3);
        exp_q.delete();
        rst = 1'b0;
        bits(2);
    endtask

    // Sends a full image; expected writes come from the word list, checksum from XOR of bytes.
    task automatic send_image(input int n, input logic [31:0] w[$], input logic [7:0] flip);
        logic [31:0] nl;
        logic [31:0] x;
        logic [7:0]  cs;
        nl = n; cs = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(nl[8*i +: 8], 1'b1);
        if (n > MAXW) return;
        for (int j = 0; j < n; j++) begin
            wr_t e;
            x = w[j];
            e.adr = 6'(j); e.dat = x;
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                cs ^= x[8*i +: 8];
                send_byte(x[8*i +: 8], 1'b1);
            end
        end
`ifdef SERVANT_LOADER_CHECKSUM_EN
        send_byte(cs ^ flip, 1'b1);
`else
        if (flip != 8'h00) cs = 8'h00;
`endif
    endtask

    task automatic expect_end(input string name, input bit exp_done);
        int c;
        c = 0;
        while (!(done || err) && c < 400) begin @(negedge clk); c++; end
        bits(4);
        chk({name, "_done"}, {63'd0, done}, {63'd0, exp_done});
        chk({name, "_err"}, {63'd0, err}, {63'd0, !exp_done});
        chk({name, "_cpu_rst"}, {63'd0, cpu_rst}, {63'd0, !exp_done});
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_mem(input logic [31:0] w[$]);
        for (int j = 0; j < w.size(); j++) chk("ram_word", {32'd0, mem[j]}, {32'd0, w[j]});
    endtask

    logic [31:0] wq[$];
    int w0;
    bit csum_on;

    initial begin
`ifdef SERVANT_LOADER_CHECKSUM_EN
        csum_on = 1'b1;
`else
        csum_on = 1'b0;
`endif
        do_reset();
        chk("rst_cyc", {63'd0, cyc}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_sel", {60'd0, sel}, 64'd0);
        chk("rst_adr", {58'd0, adr}, 64'd0);
        chk("rst_dat", {32'd0, dat}, 64'd0);
        chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);

        // Directed two-word program.
        wq = '{32'h00800413, 32'h7b241073};
        w0 = writes;
        send_image(2, wq, 8'h00);
        expect_end("n2", 1'b1);
        chk("n2_writes", 64'(writes - w0), 64'd2);
        chk_mem(wq);

        // Empty image.
        do_reset();
        wq.delete(); w0 = writes;
        send_image(0, wq, 8'h00);
        expect_end("n0", 1'b1);
        chk("n0_writes", 64'(writes - w0), 64'd0);

        // Oversized length, then a stray byte that must be ignored.
        do_reset();
        w0 = writes;
        send_image(65, wq, 8'h00);
        expect_end("n65", 1'b0);
        send_byte(8'h5A, 1'b1);
        bits(8);
        chk("n65_sticky_err", {63'd0, err}, 64'd1);
        chk("n65_writes", 64'(writes - w0), 64'd0);

        // Framing error on second payload byte.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd2 : 8'd0, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h04, 1'b0);
        expect_end("ferr", 1'b0);

        // Start glitch, then a valid one-word image.
        do_reset();
        rx = 1'b0; bits(CPB/2 - 4); rx = 1'b1; bits(2*CPB);
        wq = '{$urandom};
        send_image(1, wq, 8'h00);
        expect_end("glitch", 1'b1);
        chk_mem(wq);

        // Reset mid-payload, fresh image restarts at word 0.
        do_reset();
        wq = '{$urandom, $urandom, $urandom};
        begin
            wr_t e;
            e.adr = 6'd0; e.dat = wq[0];
            exp_q.push_back(e);
        end
        send_byte(8'd3, 1'b1);
        repeat (3) send_byte(8'd0, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(wq[i/4][8*(i%4) +: 8], 1'b1);
        chk("mid_pending", 64'(exp_q.size()), 64'd0);
        do_reset();
        chk("mid_rst_cpu", {63'd0, cpu_rst}, 64'd1);
        chk("mid_rst_cyc", {63'd0, cyc}, 64'd0);
        wq = '{$urandom};
        w0 = writes;
        send_image(1, wq, 8'h00);
        expect_end("mid_fresh", 1'b1);
        chk("mid_fresh_writes", 64'(writes - w0), 64'd1);
        chk_mem(wq);

        // Random images, plus the largest legal one.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = (t == 3) ? MAXW : int'($urandom_range(1, 4));
            do_reset();
            wq.delete();
            for (int j = 0; j < n; j++) wq.push_back($urandom);
            send_image(n, wq, 8'h00);
            expect_end("rand", 1'b1);
            chk_mem(wq);
        end

        if (csum_on) begin
            do_reset();
            wq = '{32'h11223344};
            send_image(1, wq, 8'h00);
            expect_end("csum_ok", 1'b1);
            do_reset();
            send_image(1, wq, 8'h01);
            expect_end("csum_bad", 1'b0);
            chk_mem(wq);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servant_ram_loader.md
# servant_ram_loader

Boot-time program loader placed directly upstream of the servant on-chip RAM. Receives a program image over an 8N1 serial line, assembles little-endian 32-bit words and writes them into the RAM through its Wishbone slave port, holding the CPU in reset until the image is fully written. After a successful load it releases the bus and the CPU and stays idle until the next reset.

## Interface
Parameters:
- depth, 256, RAM size in bytes (same meaning as the RAM's depth)
- aw, $clog2(depth), byte address width
- clks_per_bit, 16, clock cycles per serial bit; must be ≥ 8

Ports:
- i_wb_clk  in  1  system clock; the only clock
- i_wb_rst  in  1  reset, synchronous, active-high
- i_rx  in  1  serial input, idle high, asynchronous to i_wb_clk
- o_wb_adr  out  aw-2 ([aw-1:2])  word address to RAM
- o_wb_dat  out  32  write data
- o_wb_sel  out  4  byte enables; always 4'hF while o_wb_cyc=1
- o_wb_we  out  1  write strobe; equal to o_wb_cyc
- o_wb_cyc  out  1  cycle request
- i_wb_ack  in  1  RAM acknowledge (single-cycle pulse)
- o_cpu_rst  out  1  CPU reset; high until load succeeds
- o_done  out  1  load completed successfully
- o_err  out  1  load aborted (sticky until reset)

## Operation
- Image format: 4 length bytes N (word count, LSB first), then 4·N payload bytes (each word LSB first); with checksum enabled, one trailing checksum byte.
- Serial RX: i_rx passes a 2-flop synchroniser. Falling edge in idle starts a frame; start bit re-sampled at clks_per_bit/2 (low → continue, high → glitch, return to idle). 8 data bits LSB first sampled every clks_per_bit; stop bit sampled; stop=0 is a framing error → ERR.
- States: LEN (collect 4 length bytes), LOAD, CHECK (macro only), DONE, ERR.
- LEN → after 4th byte: N > depth/4 → ERR; N = 0 → DONE (CHECK if macro); else LOAD.
- LOAD: every 4th byte completes a word; issue write at word address 0,1,2,…; after write of word N-1 is acknowledged → DONE (CHECK if macro).
- DONE, ERR: terminal; further serial bytes ignored; bus idle.
- o_cpu_rst = 1 in every state except DONE; o_done = (state==DONE); o_err = (state==ERR).

## Timing
- Reset values: o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_cpu_rst=1, o_done=0, o_err=0; state LEN, byte/word counters 0.
- Write handshake: cycle after word completion o_wb_cyc/we=1 with stable adr/dat/sel; held until i_wb_ack sampled high; deasserted the following cycle (exactly one ack per word, compatible with a slave acking one cycle after cyc).
- Write latency: word completion to ack ≤ 3 cycles, far below one byte time (10·clks_per_bit), so the next byte can never complete while a write is pending; no buffering beyond one word register.
- Word address increments on ack; wraps never occur because N ≤ depth/4 is enforced.
- o_cpu_rst falls and o_done rises in the same cycle DONE is entered.
- Reset mid-load: all state discarded, counters 0, o_cpu_rst=1, any in-flight bus cycle dropped the next cycle; partially written RAM content is not cleared.

## Configuration
- SERVANT_LOADER_CHECKSUM_EN defined: after payload, CHECK receives one byte; equal to XOR of all 4·N payload bytes → DONE, else → ERR (RAM contents remain written, CPU stays in reset).
- Undefined: no checksum byte expected; LOAD → DONE directly after last ack; CHECK state absent.

## Structure
- Package servant_loader_pkg: state encoding constants (LEN, LOAD, CHECK, DONE, ERR), length-byte count (4), bytes-per-word (4).
- One sub-module: servant_uart_rx (synchroniser, bit timing, outputs data byte + 1-cycle valid pulse + framing-error pulse). Loader FSM, word assembly, Wishbone master and checksum live in servant_ram_loader.

## Test plan
- Load N=2, words 32'h00800413, 32'h7b241073 (clks_per_bit=16) → two writes adr 0 then 1, sel 4'hF, each cyc drops the cycle after ack; o_done=1, o_cpu_rst=0; RAM words match.
- N=0 → DONE with no bus cycle (macro on: checksum byte 8'h00 required first).
- N=65 with depth=256 → o_err=1 after 4th length byte, no bus cycle, o_cpu_rst stays 1.
- Stop bit driven low on 2nd payload byte → ERR; start glitch shorter than clks_per_bit/2 → ignored, no byte.
- Macro on, N=1, word 32'h11223344, checksum 8'h44 → DONE; checksum 8'h45 → ERR with RAM word 0 = 32'h11223344.
- Assert i_wb_rst mid-payload, then send fresh N=1 image → writes start at adr 0, o_done=1.
